// File: rtl/res_serializer.sv
// Result serializer: captures an upstream result on each rising edge of r_o_in into a FIFO and emits it as two half-words, high half first.
// Latency: a capture into an empty FIFO at edge N presents the high half after edge N+1; two cycles per entry when out_ready stays high.
// Backpressure: out_ready low holds the current half-word stable; a capture into a full FIFO (no pop that cycle) is dropped and sets sticky overflow.
module res_serializer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        r_o_in,
    input  logic [1:0]  err_in,
    input  logic [31:0] data_in,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_half,
    output logic [1:0]  out_err,
    output logic        overflow,
    output logic [4:0]  count
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    typedef enum logic [1:0] {IDLE, HI, LO} state_t;

    state_t        state, state_nxt;
    logic [33:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          r_o_prev;
    logic          capture, pop, push, drop;
    logic [4:0]    count_nxt;
    logic [33:0]   head;

    // A result is offered once per rising edge of the upstream ready level.
    assign capture   = r_o_in & ~r_o_prev;
    // The head leaves the FIFO only when its low half is accepted.
    assign pop       = (state == LO) & out_ready;
    // A full FIFO still accepts a capture if the head is popped at the same edge.
    assign push      = capture & ((count < DEPTH_C) | pop);
    assign drop      = capture & ~push;
    assign head      = mem[rd_ptr];
    assign count_nxt = count + 5'(push) - 5'(pop);

    // Edge detector, pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_o_prev <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            r_o_prev <= r_o_in;
            count    <= count_nxt;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (drop) overflow <= 1'b1;
        end
    end

    // Entry storage; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (reset && push) mem[wr_ptr] <= {err_in, data_in};
    end

    // Output state register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and outputs; outputs depend only on state and stored entries.
    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        out_half  = 1'b0;
        out_data  = 16'h0000;
        out_err   = 2'b00;
        case (state)
            IDLE: begin
                if (count != 5'd0) state_nxt = HI;
            end
            HI: begin
                out_valid = 1'b1;
                out_data  = head[31:16];
                out_err   = head[33:32];
                if (out_ready) state_nxt = LO;
            end
            LO: begin
                out_valid = 1'b1;
                out_half  = 1'b1;
                out_data  = head[15:0];
                out_err   = head[33:32];
                if (out_ready) state_nxt = (count_nxt != 5'd0) ? HI : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_res_serializer.sv
// Bench for res_serializer: directed scenarios plus random traffic against a queue-based reference.
// Latency: checks first-capture timing and back-to-back streaming explicitly.
// Backpressure: random and directed out_ready stalls; overflow and full-with-pop cases.
module tb_res_serializer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        r_o_in = 1'b0;
    logic [1:0]  err_in = 2'b00;
    logic [31:0] data_in = 32'h0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_half;
    logic [1:0]  out_err;
    logic        overflow;
    logic [4:0]  count;

    int errors = 0;
    int checks = 0;

    res_serializer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .r_o_in(r_o_in), .err_in(err_in), .data_in(data_in),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_half(out_half),
        .out_err(out_err), .overflow(overflow), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: entries are a list of results; each accepted result becomes two expected half-words.
    logic [18:0] expq[$];   // {err, half, data16}
    int          m_cnt = 0;
    bit          m_ovf = 1'b0;
    bit          m_prev = 1'b0;
    bit          m_live = 1'b0;

    // Monitor: compare outputs mid-cycle, then advance the reference across the coming edge.
    always @(negedge clk) begin
        bit cap, pop, acc;
        if (m_live) begin
            chk("count", 32'(count), 32'(m_cnt));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (m_cnt == 0) chk("idle_when_empty", 32'(out_valid), 32'd0);
            if (out_valid) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h expected no output", {out_err, out_half, out_data});
                end else begin
                    chk("half_word", 32'({out_err, out_half, out_data}), 32'(expq[0]));
                end
            end
        end
        pop = m_live && out_valid && out_ready && out_half;
        if (out_valid && out_ready && expq.size() > 0) void'(expq.pop_front());
        if (!reset) begin
            m_live = 1'b1;
            m_cnt  = 0;
            m_ovf  = 1'b0;
            m_prev = 1'b0;
            expq.delete();
        end else begin
            cap    = r_o_in && !m_prev;
            m_prev = r_o_in;
            acc    = cap && (m_cnt < DEPTH || pop);
            if (cap && !acc) m_ovf = 1'b1;
            if (acc) begin
                expq.push_back({err_in, 1'b0, data_in[31:16]});
                expq.push_back({err_in, 1'b1, data_in[15:0]});
            end
            m_cnt = m_cnt + int'(acc) - int'(pop);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic capture_one(input logic [1:0] e, input logic [31:0] d);
        r_o_in = 1'b1; err_in = e; data_in = d;
        step();
        r_o_in = 1'b0;
        step();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        step();
        step();
        reset = 1'b1;

        // Reset values
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_half", 32'(out_half), 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_count", 32'(count), 32'd0);

        // Single result with first-capture latency
        step();
        out_ready = 1'b1;
        r_o_in = 1'b1; err_in = 2'b00; data_in = 32'h40490FDB;
        step();
        r_o_in = 1'b0;
        @(negedge clk);
        chk("lat_not_yet", 32'(out_valid), 32'd0);
        step();
        @(negedge clk);
        chk("single_hi", 32'({out_valid, out_half, out_data}), {15'd0, 1'b1, 1'b0, 16'h4049});
        step();
        @(negedge clk);
        chk("single_lo", 32'({out_valid, out_half, out_data}), {15'd0, 1'b1, 1'b1, 16'h0FDB});
        step();
        @(negedge clk);
        chk("single_done", 32'({out_valid, count}), 32'd0);

        // Backpressure in HI
        out_ready = 1'b0;
        capture_one(2'b00, 32'h40490FDB);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold", 32'({out_valid, out_half, out_data}), {15'd0, 1'b1, 1'b0, 16'h4049});
            step();
        end
        out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("bp_release_lo", 32'({out_valid, out_half}), 32'd3);
        repeat (3) step();

        // Level hold yields one entry
        out_ready = 1'b0;
        r_o_in = 1'b1; data_in = 32'h3F800000;
        repeat (10) step();
        r_o_in = 1'b0;
        @(negedge clk);
        chk("level_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        repeat (4) step();

        // Overflow: DEPTH+1 captures while stalled
        out_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) capture_one(2'(i), 32'hA0000000 + 32'(i * 32'h00010001));
        @(negedge clk);
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        repeat (12) step();
        @(negedge clk);
        chk("ovf_drained", 32'(count), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        do_reset();
        @(negedge clk);
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Full FIFO with capture in the same cycle as a pop
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) capture_one(2'b01, 32'h10000000 * 32'(i + 1));
        out_ready = 1'b1;
        step();
        r_o_in = 1'b1; err_in = 2'b10; data_in = 32'hAAAA5555;
        @(negedge clk);
        chk("full_lo_count", 32'({out_half, count}), {26'd0, 1'b1, 5'd4});
        step();
        r_o_in = 1'b0;
        @(negedge clk);
        chk("full_pop_count", 32'(count), 32'd4);
        chk("full_pop_ovf", 32'(overflow), 32'd0);
        repeat (12) step();

        // Error entry, then reset during HI with a capture in the reset cycle
        out_ready = 1'b0;
        capture_one(2'b11, 32'h00000000);
        capture_one(2'b01, 32'hDEADBEEF);
        @(negedge clk);
        chk("err_hi", 32'({out_err, out_half, out_data}), {13'd0, 2'b11, 1'b0, 16'h0000});
        out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("err_lo", 32'({out_err, out_half, out_data}), {13'd0, 2'b11, 1'b1, 16'h0000});
        step();
        @(negedge clk);
        chk("second_hi", 32'({out_valid, out_half, out_data}), {15'd0, 1'b1, 1'b0, 16'hDEAD});
        reset = 1'b0; r_o_in = 1'b1;
        step();
        reset = 1'b1; r_o_in = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        repeat (3) step();
        @(negedge clk);
        chk("midrst_quiet", 32'(out_valid), 32'd0);

        // Level already high when reset deasserts
        reset = 1'b0; r_o_in = 1'b1; err_in = 2'b00; data_in = 32'h11223344;
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        chk("post_rst_capture", 32'(count), 32'd1);
        r_o_in = 1'b0;
        repeat (4) step();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0) r_o_in = ~r_o_in;
            out_ready = ($urandom_range(0, 9) < 7);
            err_in    = 2'($urandom_range(0, 3));
            data_in   = $urandom;
            reset     = ($urandom_range(0, 199) != 0);
            step();
        end
        reset = 1'b1; r_o_in = 1'b0; out_ready = 1'b1;
        repeat (20) step();
        @(negedge clk);
        chk("final_count", 32'(count), 32'd0);
        chk("final_queue", 32'(expq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
